// File: rtl/dm_port_arbiter.sv
// Two-port arbiter in front of the single synchronous-read data memory.
// Port P (pipeline) wins by default. Port A (aux/debug/DMA) wins when P is
// idle, when it has been refused MAX_WAIT times in a row, or while A holds the
// lock. The lock is force-released after LOCK_MAX cycles and o_lock_abort
// pulses for one cycle. Read data is steered back to the port that issued the
// read, one cycle after the access.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | normal arbitration: P priority, A anti-starvation via wait_cnt
//   LOCKED | A owns the memory; P is stalled; lock_cnt counts held cycles
module dm_port_arbiter #(
  parameter int ALEN     = 64,
  parameter int DLEN     = 64,
  parameter int BEN      = 8,
  parameter int MAX_WAIT = 4,
  parameter int LOCK_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_p_req,
  input  logic [ALEN-1:0] i_p_addr,
  input  logic [BEN-1:0]  i_p_wen,
  input  logic [DLEN-1:0] i_p_wdata,
  output logic            o_p_gnt,
  output logic            o_p_rvalid,
  output logic [DLEN-1:0] o_p_rdata,
  output logic            o_p_stall,
  input  logic            i_a_req,
  input  logic            i_a_lock,
  input  logic [ALEN-1:0] i_a_addr,
  input  logic [BEN-1:0]  i_a_wen,
  input  logic [DLEN-1:0] i_a_wdata,
  output logic            o_a_gnt,
  output logic            o_a_rvalid,
  output logic [DLEN-1:0] o_a_rdata,
  output logic            o_lock_abort,
  output logic [ALEN-1:0] o_mem_addr,
  output logic [BEN-1:0]  o_mem_wen,
  output logic [DLEN-1:0] o_mem_wdata,
  input  logic [DLEN-1:0] i_mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wait_cnt, wait_nx;
  logic [LW-1:0]   lock_cnt, lock_nx;
  logic            abort_nx;
  logic            p_gnt, a_gnt;
  logic            p_rvalid, a_rvalid, lock_abort;

  // Grant decision plus next state, counters and abort pulse.
  always_comb begin
    p_gnt    = 1'b0;
    a_gnt    = 1'b0;
    state_nx = state;
    lock_nx  = lock_cnt;
    abort_nx = 1'b0;
    wait_nx  = wait_cnt;

    unique case (state)
      IDLE: begin
        a_gnt = i_a_req && (!i_p_req || (wait_cnt == WW'(MAX_WAIT)));
        p_gnt = i_p_req && !a_gnt;
        if (a_gnt && i_a_lock) begin
          state_nx = LOCKED;
          lock_nx  = LW'(1);
        end
      end
      LOCKED: begin
        a_gnt = i_a_req;
        // Timeout takes precedence; an A access in this cycle still happens
        // but cannot extend the lock.
        if (lock_cnt == LW'(LOCK_MAX)) begin
          state_nx = IDLE;
          lock_nx  = '0;
          abort_nx = 1'b1;
        end else if (a_gnt && !i_a_lock) begin
          state_nx = IDLE;
          lock_nx  = '0;
        end else begin
          lock_nx  = lock_cnt + LW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        lock_nx  = '0;
      end
    endcase

    if (!i_a_req || a_gnt) begin
      wait_nx = '0;
    end else if (wait_cnt != WW'(MAX_WAIT)) begin
      wait_nx = wait_cnt + WW'(1);
    end
  end

  // State, counters and read-return flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lock_cnt   <= '0;
      p_rvalid   <= 1'b0;
      a_rvalid   <= 1'b0;
      lock_abort <= 1'b0;
    end else begin
      state      <= state_nx;
      wait_cnt   <= wait_nx;
      lock_cnt   <= lock_nx;
      p_rvalid   <= p_gnt && (i_p_wen == '0);
      a_rvalid   <= a_gnt && (i_a_wen == '0);
      lock_abort <= abort_nx;
    end
  end

  // Memory request mux: address/data default to P so the idle bus is quiet.
  always_comb begin
    o_mem_addr  = i_p_addr;
    o_mem_wdata = i_p_wdata;
    o_mem_wen   = '0;
    if (a_gnt) begin
      o_mem_addr  = i_a_addr;
      o_mem_wdata = i_a_wdata;
      o_mem_wen   = i_a_wen;
    end else if (p_gnt) begin
      o_mem_wen   = i_p_wen;
    end
  end

  assign o_p_gnt      = p_gnt;
  assign o_a_gnt      = a_gnt;
  assign o_p_stall    = i_p_req && !p_gnt;
  assign o_p_rvalid   = p_rvalid;
  assign o_a_rvalid   = a_rvalid;
  assign o_p_rdata    = p_rvalid ? i_mem_rdata : '0;
  assign o_a_rdata    = a_rvalid ? i_mem_rdata : '0;
  assign o_lock_abort = lock_abort;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: a fixed vector table, directed multi-cycle
// sequences, and a random phase, all checked against a rule-level model.
module tb_dm_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int LOCK_MAX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        p_req, a_req, a_lock;
  logic [63:0] p_addr, a_addr, p_wdata, a_wdata;
  logic [7:0]  p_wen, a_wen;
  logic        o_p_gnt, o_p_rvalid, o_p_stall, o_a_gnt, o_a_rvalid, o_lock_abort;
  logic [63:0] o_p_rdata, o_a_rdata, o_mem_addr, o_mem_wdata;
  logic [7:0]  o_mem_wen;
  logic [63:0] mem_rdata;
  logic        mem_clear;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_port_arbiter #(.ALEN(64), .DLEN(64), .BEN(8), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_p_req(p_req), .i_p_addr(p_addr), .i_p_wen(p_wen), .i_p_wdata(p_wdata),
    .o_p_gnt(o_p_gnt), .o_p_rvalid(o_p_rvalid), .o_p_rdata(o_p_rdata), .o_p_stall(o_p_stall),
    .i_a_req(a_req), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_wen(a_wen), .i_a_wdata(a_wdata),
    .o_a_gnt(o_a_gnt), .o_a_rvalid(o_a_rvalid), .o_a_rdata(o_a_rdata), .o_lock_abort(o_lock_abort),
    .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  function automatic logic [63:0] init_word(int i);
    logic [31:0] v;
    v = i;
    return {32'hA5A5_0000 ^ v, ~v};
  endfunction

  // Synchronous-read data memory, 64 words indexed by address bits [8:3].
  logic [63:0] mem_arr [0:63];
  logic [5:0]  mem_idx;
  assign mem_idx = o_mem_addr[8:3];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
    end else begin
      for (int b = 0; b < 8; b++)
        if (o_mem_wen[b]) mem_arr[mem_idx][b*8 +: 8] <= o_mem_wdata[b*8 +: 8];
    end
    mem_rdata <= mem_arr[mem_idx];
  end

  // Reference model state: plain counters and flags derived from the rules.
  logic [63:0] ref_mem [0:63];
  bit          m_locked;
  int          m_age;
  int          m_streak;
  bit          m_prv, m_arv, m_abort;
  logic [63:0] m_rdata;
  logic        last_pg, last_ag;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_age = 0; m_streak = 0;
    m_prv = 0; m_arv = 0; m_abort = 0; m_rdata = '0;
  endtask

  // One clock cycle: check all outputs against the model, then advance both.
  task automatic step();
    logic        e_pg, e_ag;
    logic [63:0] e_addr, e_wdata;
    logic [7:0]  e_wen;
    bit          nprv, narv, nabort;
    logic [63:0] nrd;
    int          idx;
    #1;
    e_ag    = a_req && (m_locked || !p_req || m_streak >= MAX_WAIT);
    e_pg    = p_req && !m_locked && !e_ag;
    e_addr  = e_ag ? a_addr : p_addr;
    e_wdata = e_ag ? a_wdata : p_wdata;
    e_wen   = e_ag ? a_wen : (e_pg ? p_wen : 8'h00);
    chk("p_gnt",     64'(o_p_gnt),      64'(e_pg));
    chk("a_gnt",     64'(o_a_gnt),      64'(e_ag));
    chk("p_stall",   64'(o_p_stall),    64'(p_req && !e_pg));
    chk("mem_addr",  o_mem_addr,        e_addr);
    chk("mem_wen",   64'(o_mem_wen),    64'(e_wen));
    chk("mem_wdata", o_mem_wdata,       e_wdata);
    chk("p_rvalid",  64'(o_p_rvalid),   64'(m_prv));
    chk("a_rvalid",  64'(o_a_rvalid),   64'(m_arv));
    chk("p_rdata",   o_p_rdata,         m_prv ? m_rdata : 64'h0);
    chk("a_rdata",   o_a_rdata,         m_arv ? m_rdata : 64'h0);
    chk("lock_abort", 64'(o_lock_abort), 64'(m_abort));
    last_pg = o_p_gnt;
    last_ag = o_a_gnt;
    @(posedge clk);
    nprv = 0; narv = 0; nrd = '0; nabort = 0;
    if (e_pg || e_ag) begin
      idx = int'(e_addr[8:3]);
      if (e_wen == 8'h00) begin
        nrd  = ref_mem[idx];
        nprv = e_pg;
        narv = e_ag;
      end else begin
        for (int b = 0; b < 8; b++)
          if (e_wen[b]) ref_mem[idx][b*8 +: 8] = e_wdata[b*8 +: 8];
      end
    end
    if (m_locked) begin
      if (m_age == LOCK_MAX) begin
        m_locked = 0; nabort = 1;
      end else if (e_ag && !a_lock) begin
        m_locked = 0;
      end else begin
        m_age++;
      end
    end else if (e_ag && a_lock) begin
      m_locked = 1; m_age = 1;
    end
    m_streak = (a_req && !e_ag) ? ((m_streak + 1 > MAX_WAIT) ? MAX_WAIT : m_streak + 1) : 0;
    m_prv = nprv; m_arv = narv; m_rdata = nrd; m_abort = nabort;
    if (rst) model_reset();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rst = 0; p_req = 0; a_req = 0; a_lock = 0;
    p_wen = '0; a_wen = '0; p_addr = '0; a_addr = '0;
    p_wdata = '0; a_wdata = '0;
  endtask

  typedef struct {
    bit         p_req;
    bit         a_req;
    bit         a_lock;
    logic [7:0] a_wen;
    bit         pg, ag, st, prv, arv;
  } vec_t;

  function automatic vec_t mk(bit pr, bit ar, bit al, logic [7:0] aw,
                              bit pg, bit ag, bit st, bit prv, bit arv);
    vec_t v;
    v.p_req = pr; v.a_req = ar; v.a_lock = al; v.a_wen = aw;
    v.pg = pg; v.ag = ag; v.st = st; v.prv = prv; v.arv = arv;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [17];
    int   n;

    // Rows start straight after reset (IDLE, wait 0). P reads 0x10, A uses 0x18.
    tbl[0]  = mk(1,0,0,8'h00, 1,0,0,0,0);
    tbl[1]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[2]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[3]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[4]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[5]  = mk(1,1,0,8'h00, 0,1,1,1,0);
    tbl[6]  = mk(1,1,0,8'h00, 1,0,0,0,1);
    tbl[7]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[8]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[9]  = mk(1,1,0,8'h00, 1,0,0,1,0);
    tbl[10] = mk(1,1,0,8'h00, 0,1,1,1,0);
    tbl[11] = mk(0,0,0,8'h00, 0,0,0,0,1);
    tbl[12] = mk(0,1,1,8'hFF, 0,1,0,0,0);
    tbl[13] = mk(1,0,0,8'h00, 0,0,1,0,0);
    tbl[14] = mk(1,1,0,8'h00, 0,1,1,0,0);
    tbl[15] = mk(1,0,0,8'h00, 1,0,0,0,1);
    tbl[16] = mk(0,0,0,8'h00, 0,0,0,1,0);

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    idle_inputs();
    rst = 1; mem_clear = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0; mem_clear = 0;
    model_reset();

    // Vector table.
    for (int i = 0; i < 17; i++) begin
      p_req = tbl[i].p_req; p_addr = 64'h10; p_wen = 8'h00;
      a_req = tbl[i].a_req; a_lock = tbl[i].a_lock; a_addr = 64'h18;
      a_wen = tbl[i].a_wen; a_wdata = 64'h1234_5678_9ABC_DEF0;
      #1;
      chk("tbl_p_gnt",    64'(o_p_gnt),    64'(tbl[i].pg));
      chk("tbl_a_gnt",    64'(o_a_gnt),    64'(tbl[i].ag));
      chk("tbl_p_stall",  64'(o_p_stall),  64'(tbl[i].st));
      chk("tbl_p_rvalid", 64'(o_p_rvalid), 64'(tbl[i].prv));
      chk("tbl_a_rvalid", 64'(o_a_rvalid), 64'(tbl[i].arv));
      if (i == 1) chk("tbl_p_rdata_0x10", o_p_rdata, init_word(2));
      step();
    end

    // Locked write/read-back by A while P keeps requesting.
    idle_inputs();
    p_req = 1; p_addr = 64'h40;
    a_req = 1; a_lock = 1; a_addr = 64'h20; a_wen = 8'hFF; a_wdata = 64'h0000_0000_DEAD_BEEF;
    n = 0; last_ag = 0;
    while (!last_ag && n < 10) begin
      step();
      n++;
    end
    chk("lockwr_cycles_to_grant", 64'(n), 64'd5);
    chk("lockwr_p_gnt", 64'(last_pg), 64'd0);
    a_lock = 0; a_wen = 8'h00;
    #1;
    chk("lockrd_p_gnt", 64'(o_p_gnt), 64'd0);
    chk("lockrd_a_gnt", 64'(o_a_gnt), 64'd1);
    step();
    a_req = 0;
    #1;
    chk("lockrd_p_gnt_after", 64'(o_p_gnt), 64'd1);
    chk("lockrd_a_rvalid", 64'(o_a_rvalid), 64'd1);
    chk("lockrd_a_rdata", o_a_rdata, 64'h0000_0000_DEAD_BEEF);
    step();

    // Lock held with A idle: forced release after LOCK_MAX cycles.
    idle_inputs();
    a_req = 1; a_lock = 1; a_addr = 64'h28;
    step();
    a_req = 0; a_lock = 0; p_req = 1; p_addr = 64'h30;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (o_lock_abort) break;
      step();
      n++;
    end
    chk("abort_locked_cycles", 64'(n), 64'(LOCK_MAX));
    chk("abort_pulse", 64'(o_lock_abort), 64'd1);
    chk("abort_p_gnt", 64'(o_p_gnt), 64'd1);
    step();
    #1;
    chk("abort_single_pulse", 64'(o_lock_abort), 64'd0);
    step();

    // Reset in the cycle of an accepted read squashes its rvalid.
    idle_inputs();
    p_req = 1; p_addr = 64'h10; rst = 1;
    #1;
    chk("rst_read_accepted", 64'(o_p_gnt), 64'd1);
    step();
    idle_inputs();
    #1;
    chk("rst_p_rvalid", 64'(o_p_rvalid), 64'd0);
    chk("rst_a_rvalid", 64'(o_a_rvalid), 64'd0);
    chk("rst_p_rdata",  o_p_rdata, 64'd0);
    chk("rst_grants",   64'({o_p_gnt, o_a_gnt}), 64'd0);
    chk("rst_abort",    64'(o_lock_abort), 64'd0);
    chk("rst_mem_wen",  64'(o_mem_wen), 64'd0);
    step();

    // Reset while locked returns the arbiter to IDLE.
    a_req = 1; a_lock = 1; a_addr = 64'h28;
    step();
    idle_inputs();
    p_req = 1; rst = 1;
    #1;
    chk("rstlock_p_gnt_blocked", 64'(o_p_gnt), 64'd0);
    step();
    rst = 0;
    #1;
    chk("rstlock_p_gnt_released", 64'(o_p_gnt), 64'd1);
    step();

    // Alternating P read 0x08 / A read 0x18: data returns to the right port.
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      p_req = (i % 2 == 0); p_addr = 64'h08;
      a_req = (i % 2 == 1); a_addr = 64'h18;
      #1;
      chk("alt_not_both", 64'(o_p_rvalid && o_a_rvalid), 64'd0);
      if (i > 0 && i % 2 == 1) begin
        chk("alt_p_rvalid", 64'(o_p_rvalid), 64'd1);
        chk("alt_p_rdata",  o_p_rdata, ref_mem[1]);
      end
      if (i > 0 && i % 2 == 0) begin
        chk("alt_a_rvalid", 64'(o_a_rvalid), 64'd1);
        chk("alt_a_rdata",  o_a_rdata, ref_mem[3]);
      end
      step();
    end

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      rst     = ($urandom_range(0, 99) == 0);
      p_req   = ($urandom_range(0, 3) != 0);
      a_req   = ($urandom_range(0, 1) == 1);
      a_lock  = ($urandom_range(0, 3) == 0);
      p_addr  = 64'($urandom_range(0, 7)) << 3;
      a_addr  = 64'($urandom_range(0, 7)) << 3;
      p_wen   = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom);
      a_wen   = ($urandom_range(0, 9) < 6) ? 8'h00 : 8'($urandom);
      p_wdata = {$urandom, $urandom};
      a_wdata = {$urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
